// File: rtl/regfile_mp_if.sv
// Operation/read bus between decode (master) and the multi-ported register file (slave).
interface regfile_mp_if #(
  parameter int W     = 8,
  parameter int D     = 4,
  parameter int IMM_W = 8,
  parameter int NRD   = 2
) ();
  logic               OpValid;
  logic               OpReady;
  logic [2:0]         Op;
  logic [D-1:0]       DstAddr;
  logic [D-1:0]       SrcAddr;
  logic [W-1:0]       WrData;
  logic [IMM_W-1:0]   Imm;
  logic [NRD*D-1:0]   RdAddr;
  logic [NRD*W-1:0]   RdData;
  logic [W-1:0]       Acc0;
  logic [W-1:0]       Acc1;
  logic               Busy;

  modport master (
    output OpValid, Op, DstAddr, SrcAddr, WrData, Imm, RdAddr,
    input  OpReady, RdData, Acc0, Acc1, Busy
  );

  modport slave (
    input  OpValid, Op, DstAddr, SrcAddr, WrData, Imm, RdAddr,
    output OpReady, RdData, Acc0, Acc1, Busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-ported register file: one physical write port, NRD combinational read ports,
// accumulator taps on R0/R1, optional write-to-read bypass and a two-cycle SWAP.
module regfile_mp #(
  parameter int W      = 8,
  parameter int D      = 4,
  parameter int IMM_W  = 8,
  parameter int NRD    = 2,
  parameter int BYPASS = 1
) (
  input logic         Clk,
  input logic         ResetN,
  regfile_mp_if.slave bus
);

  localparam int NREG = 1 << D;

  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_LDI   = 3'd2;
  localparam logic [2:0] OP_MOVE  = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } state_e;

  state_e           state;
  state_e           state_nxt;

  logic [W-1:0]     mem [NREG];
  logic [W-1:0]     temp;
  logic [D-1:0]     swap_src;

  logic             accept;
  logic             op_ready;
  logic             busy;
  logic             start_swap;
  logic             wr_en;
  logic [D-1:0]     wr_addr;
  logic [W-1:0]     wr_data;
  logic [W-1:0]     imm_ext;

  logic [NRD*W-1:0] rd_data;
  logic [W-1:0]     acc0;
  logic [W-1:0]     acc1;

  assign accept = bus.OpValid && ResetN && (state == IDLE);

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && bus.Op == OP_SWAP) state_nxt = SWAP2;
      SWAP2:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single write port: decide what (if anything) lands in the array at this edge.
  always_comb begin
    op_ready   = 1'b0;
    busy       = 1'b0;
    start_swap = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = '0;
    wr_data    = '0;
    imm_ext    = '0;
    imm_ext[IMM_W-1:0] = bus.Imm;
    case (state)
      IDLE: begin
        op_ready = ResetN;
        if (accept) begin
          case (bus.Op)
            OP_WRITE: begin
              wr_en   = 1'b1;
              wr_addr = bus.DstAddr;
              wr_data = bus.WrData;
            end
            OP_LDI: begin
              wr_en   = 1'b1;
              wr_addr = '0;
              wr_data = imm_ext;
            end
            OP_MOVE: begin
              wr_en   = 1'b1;
              wr_addr = bus.DstAddr;
              wr_data = mem[bus.SrcAddr];
            end
            OP_SWAP: begin
              wr_en      = 1'b1;
              start_swap = 1'b1;
              wr_addr    = bus.DstAddr;
              wr_data    = mem[bus.SrcAddr];
            end
            default: ;
          endcase
        end
      end
      SWAP2: begin
        busy    = ResetN;
        wr_en   = ResetN;
        wr_addr = swap_src;
        wr_data = temp;
      end
      default: ;
    endcase
  end

  // The second SWAP half uses addresses captured at acceptance, not the live bus.
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      temp     <= '0;
      swap_src <= '0;
    end else if (start_swap) begin
      temp     <= mem[bus.DstAddr];
      swap_src <= bus.SrcAddr;
    end
  end

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // With bypass enabled a read of the address being written returns the new data.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      rd_data[k*W +: W] = ((BYPASS != 0) && wr_en && (wr_addr == bus.RdAddr[k*D +: D]))
                          ? wr_data : mem[bus.RdAddr[k*D +: D]];
    end
  end

  assign acc0 = ((BYPASS != 0) && wr_en && (wr_addr == '0))    ? wr_data : mem[0];
  assign acc1 = ((BYPASS != 0) && wr_en && (wr_addr == D'(1))) ? wr_data : mem[1];

  assign bus.OpReady = op_ready;
  assign bus.Busy    = busy;
  assign bus.RdData  = rd_data;
  assign bus.Acc0    = acc0;
  assign bus.Acc1    = acc1;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: drives an 8-bit bypassing instance and a 16-bit non-bypassing instance
// with identical operations and checks both against an array-level reference model.
module tb_regfile_mp;

  logic Clk = 1'b0;
  logic ResetN;

  always #5 Clk = ~Clk;

  regfile_mp_if #(.W(8),  .D(4), .IMM_W(8), .NRD(2)) busA ();
  regfile_mp_if #(.W(16), .D(4), .IMM_W(8), .NRD(2)) busB ();

  regfile_mp #(.W(8),  .D(4), .IMM_W(8), .NRD(2), .BYPASS(1)) dutA (
    .Clk(Clk), .ResetN(ResetN), .bus(busA));
  regfile_mp #(.W(16), .D(4), .IMM_W(8), .NRD(2), .BYPASS(0)) dutB (
    .Clk(Clk), .ResetN(ResetN), .bus(busB));

  typedef struct packed {
    bit        rstn;
    bit        valid;
    bit [2:0]  op;
    bit [3:0]  dst;
    bit [3:0]  src;
    bit [15:0] wdata;
    bit [7:0]  imm;
    bit [3:0]  ra0;
    bit [3:0]  ra1;
  } stim_t;

  typedef struct {
    bit        ready;
    bit        busy;
    bit [7:0]  a_rd0, a_rd1, a_acc0, a_acc1;
    bit [15:0] b_rd0, b_rd1, b_acc0, b_acc1;
  } exp_t;

  exp_t      sbq[$];
  int        total = 0;
  int        bad   = 0;

  // Reference state: register contents plus the outstanding half of a SWAP.
  bit [15:0] refArr [16];
  bit        pend;
  bit [3:0]  pendSrc;
  bit [15:0] pendTmp;

  function automatic stim_t mk(bit rstn, bit valid, bit [2:0] op, bit [3:0] dst, bit [3:0] src,
                               bit [15:0] wdata, bit [7:0] imm, bit [3:0] ra0, bit [3:0] ra1);
    stim_t s;
    s.rstn = rstn; s.valid = valid; s.op = op; s.dst = dst; s.src = src;
    s.wdata = wdata; s.imm = imm; s.ra0 = ra0; s.ra1 = ra1;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    exp_t      e;
    bit        wen;
    bit [3:0]  waddr;
    bit [15:0] wdat;
    bit [15:0] old [16];
    bit        acc;
    @(posedge Clk);
    #1;
    ResetN       = s.rstn;
    busA.OpValid = s.valid;  busB.OpValid = s.valid;
    busA.Op      = s.op;     busB.Op      = s.op;
    busA.DstAddr = s.dst;    busB.DstAddr = s.dst;
    busA.SrcAddr = s.src;    busB.SrcAddr = s.src;
    busA.WrData  = s.wdata[7:0];
    busB.WrData  = s.wdata;
    busA.Imm     = s.imm;    busB.Imm     = s.imm;
    busA.RdAddr  = {s.ra1, s.ra0};
    busB.RdAddr  = {s.ra1, s.ra0};

    old   = refArr;
    wen   = 1'b0;
    waddr = '0;
    wdat  = '0;
    acc   = s.rstn && !pend && s.valid;
    if (s.rstn && pend) begin
      wen = 1'b1; waddr = pendSrc; wdat = pendTmp;
    end else if (acc) begin
      case (s.op)
        3'd1: begin wen = 1'b1; waddr = s.dst; wdat = s.wdata; end
        3'd2: begin wen = 1'b1; waddr = 4'd0;  wdat = {8'h00, s.imm}; end
        3'd3, 3'd4: begin wen = 1'b1; waddr = s.dst; wdat = old[s.src]; end
        default: ;
      endcase
    end

    e.ready  = s.rstn && !pend;
    e.busy   = s.rstn && pend;
    e.a_rd0  = (wen && waddr == s.ra0)  ? wdat[7:0] : old[s.ra0][7:0];
    e.a_rd1  = (wen && waddr == s.ra1)  ? wdat[7:0] : old[s.ra1][7:0];
    e.a_acc0 = (wen && waddr == 4'd0)   ? wdat[7:0] : old[0][7:0];
    e.a_acc1 = (wen && waddr == 4'd1)   ? wdat[7:0] : old[1][7:0];
    e.b_rd0  = old[s.ra0];
    e.b_rd1  = old[s.ra1];
    e.b_acc0 = old[0];
    e.b_acc1 = old[1];
    sbq.push_back(e);

    if (!s.rstn) begin
      foreach (refArr[i]) refArr[i] = '0;
      pend = 1'b0;
    end else begin
      if (wen) refArr[waddr] = wdat;
      if (pend) begin
        pend = 1'b0;
      end else if (acc && s.op == 3'd4) begin
        pend    = 1'b1;
        pendSrc = s.src;
        pendTmp = old[s.dst];
      end
    end
  endtask

  // Monitor: the DUT presents a fresh read view every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        checkOutput("A.OpReady", {15'd0, busA.OpReady}, {15'd0, e.ready});
        checkOutput("A.Busy",    {15'd0, busA.Busy},    {15'd0, e.busy});
        checkOutput("A.RdData0", {8'd0, busA.RdData[7:0]},  {8'd0, e.a_rd0});
        checkOutput("A.RdData1", {8'd0, busA.RdData[15:8]}, {8'd0, e.a_rd1});
        checkOutput("A.Acc0",    {8'd0, busA.Acc0}, {8'd0, e.a_acc0});
        checkOutput("A.Acc1",    {8'd0, busA.Acc1}, {8'd0, e.a_acc1});
        checkOutput("B.OpReady", {15'd0, busB.OpReady}, {15'd0, e.ready});
        checkOutput("B.Busy",    {15'd0, busB.Busy},    {15'd0, e.busy});
        checkOutput("B.RdData0", busB.RdData[15:0],  e.b_rd0);
        checkOutput("B.RdData1", busB.RdData[31:16], e.b_rd1);
        checkOutput("B.Acc0",    busB.Acc0, e.b_acc0);
        checkOutput("B.Acc1",    busB.Acc1, e.b_acc1);
      end
    end
  end

  initial begin
    stim_t s;
    ResetN = 1'b0;
    busA.OpValid = 1'b0; busA.Op = '0; busA.DstAddr = '0; busA.SrcAddr = '0;
    busA.WrData = '0; busA.Imm = '0; busA.RdAddr = '0;
    busB.OpValid = 1'b0; busB.Op = '0; busB.DstAddr = '0; busB.SrcAddr = '0;
    busB.WrData = '0; busB.Imm = '0; busB.RdAddr = '0;
    foreach (refArr[i]) refArr[i] = '0;
    pend = 1'b0; pendSrc = '0; pendTmp = '0;
    repeat (2) @(posedge Clk);

    $display("[TB] directed sequence");
    applyStimulus(mk(1, 1, 3'd1, 4'd5, 4'd0, 16'h00A5, 8'h00, 4'd5, 4'd0));
    applyStimulus(mk(0, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd5, 4'd0));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd5, 4'd0));
    applyStimulus(mk(1, 1, 3'd1, 4'd3, 4'd0, 16'h003C, 8'h00, 4'd3, 4'd0));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd3, 4'd0));
    applyStimulus(mk(1, 1, 3'd2, 4'd9, 4'd9, 16'hFFFF, 8'h7F, 4'd0, 4'd1));
    applyStimulus(mk(1, 1, 3'd3, 4'd7, 4'd0, 16'h0000, 8'h00, 4'd7, 4'd0));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd7, 4'd0));
    applyStimulus(mk(1, 1, 3'd1, 4'd2, 4'd0, 16'h0011, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 1, 3'd1, 4'd9, 4'd0, 16'h0022, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 1, 3'd4, 4'd2, 4'd9, 16'h0000, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 1, 3'd1, 4'd5, 4'd1, 16'h0099, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 1, 3'd1, 4'd5, 4'd1, 16'h0099, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd2, 4'd5));
    applyStimulus(mk(1, 1, 3'd4, 4'd2, 4'd9, 16'h0000, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(0, 1, 3'd1, 4'd3, 4'd0, 16'h00EE, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd2, 4'd9));
    applyStimulus(mk(1, 1, 3'd1, 4'd4, 4'd0, 16'h005A, 8'h00, 4'd4, 4'd0));
    applyStimulus(mk(1, 1, 3'd4, 4'd4, 4'd4, 16'h0000, 8'h00, 4'd4, 4'd0));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd4, 4'd0));
    applyStimulus(mk(1, 1, 3'd3, 4'd4, 4'd4, 16'h0000, 8'h00, 4'd4, 4'd0));
    applyStimulus(mk(1, 1, 3'd6, 4'd4, 4'd1, 16'hFFFF, 8'hFF, 4'd4, 4'd0));
    applyStimulus(mk(1, 1, 3'd1, 4'd15, 4'd0, 16'hBEEF, 8'h00, 4'd15, 4'd0));
    applyStimulus(mk(1, 1, 3'd4, 4'd0, 4'd15, 16'h0000, 8'h00, 4'd15, 4'd0));
    applyStimulus(mk(1, 0, 3'd0, 4'd0, 4'd0, 16'h0000, 8'h00, 4'd15, 4'd0));

    $display("[TB] random sequence");
    for (int n = 0; n < 600; n++) begin
      s.rstn  = ($urandom_range(0, 39) != 0);
      s.valid = ($urandom_range(0, 3) != 0);
      s.op    = 3'($urandom_range(0, 7));
      s.dst   = 4'($urandom_range(0, 15));
      s.src   = 4'($urandom_range(0, 15));
      s.wdata = 16'($urandom);
      s.imm   = 8'($urandom);
      s.ra0   = ($urandom_range(0, 1) != 0) ? s.dst : 4'($urandom_range(0, 15));
      s.ra1   = ($urandom_range(0, 1) != 0) ? s.src : 4'($urandom_range(0, 15));
      applyStimulus(s);
    end

    @(posedge Clk);
    @(negedge Clk);
    #1;
    checkOutput("scoreboard.drained", 16'(sbq.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised, multi-ported successor to the datapath's 8-bit special-function register file.
- Adds the following over the previous generation:
  - N generic combinational read ports plus fixed accumulator taps.
  - An operation handshake.
  - An optional write-to-read bypass.
  - A two-cycle SWAP sequenced through the single physical write port.
  - Synchronous reset of the whole array.
- Sits between decode and the ALU. Decode issues one register operation per cycle; ALU operands come from the read ports.

Parameters:
- W, 8, data width in bits.
- D, 4, address width; the array holds 2**D registers.
- IMM_W, 8, immediate width. Must satisfy IMM_W <= W; the immediate is zero-extended to W.
- NRD, 2, number of generic read ports (1..4).
- BYPASS, 1, 1 = reads see the value being written this cycle; 0 = reads see only the stored array.

Ports:
- Clk  in  1  clock, all state updates on its rising edge.
- ResetN  in  1  synchronous active-low reset.
- OpValid  in  1  operation request.
- OpReady  out  1  block can accept an operation this cycle.
- Op  in  3  operation code: 0 NOP, 1 WRITE, 2 LDI, 3 MOVE, 4 SWAP; 5-7 are treated as NOP.
- DstAddr  in  D  destination register (WRITE, MOVE, SWAP).
- SrcAddr  in  D  source register (MOVE, SWAP).
- WrData  in  W  data for WRITE.
- Imm  in  IMM_W  immediate for LDI; always targets register 0.
- RdAddr  in  NRD*D  packed read addresses; port k uses bits [k*D +: D].
- RdData  out  NRD*W  packed read data; port k uses bits [k*W +: W].
- Acc0  out  W  contents of register 0 (bypass rules apply).
- Acc1  out  W  contents of register 1 (bypass rules apply).
- Busy  out  1  high during the second SWAP cycle.

Behaviour:
- Reset: while ResetN = 0 at a rising edge:
  - All 2**D registers become 0.
  - The FSM goes to IDLE and the temp register becomes 0.
  - OpReady = 0 combinationally while ResetN = 0. Busy = 0.
  - RdData, Acc0 and Acc1 read the array, which is 0 after the first reset edge.
- Reset mid-SWAP aborts the operation. No partial write survives, because every register is cleared.
- FSM states: IDLE and SWAP2.
  - OpReady = (state == IDLE) and ResetN.
  - Busy = (state == SWAP2).
- An operation is accepted when OpValid and OpReady are both high at a rising edge.
- OpValid while OpReady = 0 is ignored; the requester must hold the request.
- Accepted operations in IDLE:
  - WRITE: R[DstAddr] <= WrData. One cycle.
  - LDI: R[0] <= zero-extended Imm. One cycle.
  - MOVE: R[DstAddr] <= R[SrcAddr], using the pre-edge value. One cycle.
  - SWAP:
    - Cycle 1: Temp <= R[DstAddr], R[DstAddr] <= R[SrcAddr]; next state SWAP2.
    - Cycle 2 (SWAP2): R[SrcAddr] <= Temp; next state IDLE.
    - SrcAddr and DstAddr are latched at acceptance; input changes during SWAP2 are ignored.
  - NOP and codes 5-7: no state change.
- Exactly one array write occurs per cycle at most.
- Reads are combinational from the array for every RdData port, Acc0 and Acc1.
- Bypass, when BYPASS = 1:
  - If a write to address X is scheduled for the current edge (accepted WRITE/LDI/MOVE/SWAP cycle 1, or SWAP2), any read of X returns the data being written instead of the stored value.
  - This applies to all read ports and to Acc0 and Acc1.
- When BYPASS = 0, reads return the stored value only; the new value is visible the cycle after the write.
- Boundary cases:
  - MOVE with SrcAddr == DstAddr leaves the value unchanged.
  - SWAP with SrcAddr == DstAddr still takes 2 cycles and leaves the value unchanged.
  - Addresses wrap naturally within D bits; every address is valid, including 0 and 2**D-1.
- Latency:
  - Write to read-visible: 0 cycles with BYPASS = 1, 1 cycle with BYPASS = 0.
  - SWAP occupies the port for 2 cycles; the next operation is accepted in the cycle after SWAP2.

Test Plan:
- Reset clears the array: write 0xA5 to R5, then hold ResetN = 0 for 1 cycle → RdData(R5) = 0x00, Acc0 = 0, OpReady = 0 during reset and 1 the following cycle.
- WRITE with bypass: BYPASS = 1, WRITE R3 = 0x3C with RdAddr0 = 3 in the same cycle → RdData0 = 0x3C before the edge. Repeat with BYPASS = 0 → RdData0 = old value (0x00) before the edge and 0x3C after it.
- LDI into R0: Imm = 0x7F with W = 16 → Acc0 = 0x007F. Then MOVE R7 <= R0 → R7 = 0x007F, and R0 is unchanged.
- SWAP sequencing: R2 = 0x11, R9 = 0x22, SWAP Dst = 2, Src = 9.
  - Cycle 1: OpReady = 1.
  - Cycle 2: Busy = 1, OpReady = 0; a WRITE held on OpValid is not accepted.
  - Cycle 3: R2 = 0x22, R9 = 0x11, and the held WRITE is accepted.
- Reset mid-SWAP: assert ResetN = 0 in the SWAP2 cycle → all registers 0, state IDLE, Busy = 0. No 0x11 or 0x22 value remains.
- Degenerate operations: SWAP Dst = Src = 4 with R4 = 0x5A → 2 cycles, R4 = 0x5A. Op = 6 → no change to any register.
